// File: rtl/cs_next_addr_seq_pkg.sv
// rtl/cs_next_addr_seq_pkg.sv - shared encodings for the microsequencer next-address stage
//
// Purpose : COND field encodings, FSM state encodings, decode-address prefix,
//           default bus-error trap address and the decode-address helper.
// Ports   : none (package).
package cs_next_addr_seq_pkg;

  typedef enum logic [2:0] {
    COND_NEXT   = 3'b000,
    COND_N      = 3'b001,
    COND_Z      = 3'b010,
    COND_V      = 3'b011,
    COND_C      = 3'b100,
    COND_IR13   = 3'b101,
    COND_JUMP   = 3'b110,
    COND_DECODE = 3'b111
  } cond_e;

  typedef enum logic {
    ST_RUN  = 1'b0,
    ST_WAIT = 1'b1
  } state_e;

  // Opcode-decode routines live in the upper half of the control store.
  localparam logic DECODE_PREFIX = 1'b1;

  localparam logic [10:0] DEFAULT_TRAP_ADDR = 11'h7F0;

  // Each decoded opcode gets a four-microword slot.
  function automatic logic [10:0] decode_addr(input logic [1:0] ir_op, input logic [5:0] ir_op3);
    return {DECODE_PREFIX, ir_op, ir_op3, 2'b00};
  endfunction

endpackage

// File: rtl/cs_next_addr_seq_if.sv
// rtl/cs_next_addr_seq_if.sv - select/handshake bundle between microsequencer and next-address stage
//
// Purpose : groups the microword select fields, IR/PSR inputs, memory handshake
//           and the registered address/stall/bus-error outputs.
// Modports: master - drives select inputs and ACK, observes CS_OUT/STALL/BUS_ERR.
//           slave  - the next-address stage.
interface cs_next_addr_seq_if #(
  parameter int DATAWIDTH_BUS = 11
);
  import cs_next_addr_seq_pkg::*;

  logic [DATAWIDTH_BUS-1:0] CSAI_IN;
  logic [2:0]               COND;
  logic [DATAWIDTH_BUS-1:0] JUMP_ADDR;
  logic [1:0]               IR_OP;
  logic [5:0]               IR_OP3;
  logic                     IR_BIT13;
  logic                     PSR_N;
  logic                     PSR_Z;
  logic                     PSR_V;
  logic                     PSR_C;
  logic                     MEM_REQ;
  logic                     ACK;
  logic [DATAWIDTH_BUS-1:0] CS_OUT;
  logic                     STALL;
  logic                     BUS_ERR;

  modport master (
    output CSAI_IN, COND, JUMP_ADDR, IR_OP, IR_OP3, IR_BIT13,
           PSR_N, PSR_Z, PSR_V, PSR_C, MEM_REQ, ACK,
    input  CS_OUT, STALL, BUS_ERR
  );

  modport slave (
    input  CSAI_IN, COND, JUMP_ADDR, IR_OP, IR_OP3, IR_BIT13,
           PSR_N, PSR_Z, PSR_V, PSR_C, MEM_REQ, ACK,
    output CS_OUT, STALL, BUS_ERR
  );

endinterface

// File: rtl/cs_next_addr_seq_mux.sv
// rtl/cs_next_addr_seq_mux.sv - combinational next-address select
//
// Purpose : picks incremented, jump or decode address from COND, PSR flags and IR.
// Ports   : CSAI_IN, COND, JUMP_ADDR, IR_OP, IR_OP3, IR_BIT13, PSR_N/Z/V/C in;
//           NEXT_ADDR out.
module cs_next_addr_mux
  import cs_next_addr_seq_pkg::*;
#(
  parameter int DATAWIDTH_BUS = 11
) (
  input  logic [DATAWIDTH_BUS-1:0] CSAI_IN,
  input  logic [2:0]               COND,
  input  logic [DATAWIDTH_BUS-1:0] JUMP_ADDR,
  input  logic [1:0]               IR_OP,
  input  logic [5:0]               IR_OP3,
  input  logic                     IR_BIT13,
  input  logic                     PSR_N,
  input  logic                     PSR_Z,
  input  logic                     PSR_V,
  input  logic                     PSR_C,
  output logic [DATAWIDTH_BUS-1:0] NEXT_ADDR
);

  always_comb begin
    NEXT_ADDR = CSAI_IN;
    case (cond_e'(COND))
      COND_NEXT:   NEXT_ADDR = CSAI_IN;
      COND_N:      NEXT_ADDR = PSR_N    ? JUMP_ADDR : CSAI_IN;
      COND_Z:      NEXT_ADDR = PSR_Z    ? JUMP_ADDR : CSAI_IN;
      COND_V:      NEXT_ADDR = PSR_V    ? JUMP_ADDR : CSAI_IN;
      COND_C:      NEXT_ADDR = PSR_C    ? JUMP_ADDR : CSAI_IN;
      COND_IR13:   NEXT_ADDR = IR_BIT13 ? JUMP_ADDR : CSAI_IN;
      COND_JUMP:   NEXT_ADDR = JUMP_ADDR;
      COND_DECODE: NEXT_ADDR = DATAWIDTH_BUS'(decode_addr(IR_OP, IR_OP3));
      default:     NEXT_ADDR = CSAI_IN;
    endcase
  end

endmodule

// File: rtl/cs_next_addr_seq.sv
// rtl/cs_next_addr_seq.sv - microsequencer next-address register with memory-wait stall
//
// Purpose : registers the selected control-store address and holds it while a
//           microword memory access waits for ACK.
// Ports   : CLK    - clock, rising edge.
//           RESET  - synchronous, active-low.
//           bus    - cs_next_addr_seq_if.slave: select inputs, MEM_REQ/ACK,
//                    CS_OUT, STALL, BUS_ERR.
// Config  : CS_TIMEOUT_EN - when defined, a WAIT lasting TIMEOUT_CYCLES without
//           ACK jumps to TRAP_ADDR and pulses BUS_ERR; otherwise BUS_ERR is 0.
module cs_next_addr_seq
  import cs_next_addr_seq_pkg::*;
#(
  parameter int                       DATAWIDTH_BUS  = 11,
  parameter int                       TIMEOUT_CYCLES = 255,
  parameter logic [DATAWIDTH_BUS-1:0] TRAP_ADDR      = DATAWIDTH_BUS'(DEFAULT_TRAP_ADDR)
) (
  input  logic                CLK,
  input  logic                RESET,
  cs_next_addr_seq_if.slave   bus
);

  logic [DATAWIDTH_BUS-1:0] next_addr;
  logic [DATAWIDTH_BUS-1:0] cs_q, cs_d;
  state_e                   state_q, state_d;
  logic [7:0]               cnt_q, cnt_d;

  cs_next_addr_mux #(.DATAWIDTH_BUS(DATAWIDTH_BUS)) u_mux (
    .CSAI_IN   (bus.CSAI_IN),
    .COND      (bus.COND),
    .JUMP_ADDR (bus.JUMP_ADDR),
    .IR_OP     (bus.IR_OP),
    .IR_OP3    (bus.IR_OP3),
    .IR_BIT13  (bus.IR_BIT13),
    .PSR_N     (bus.PSR_N),
    .PSR_Z     (bus.PSR_Z),
    .PSR_V     (bus.PSR_V),
    .PSR_C     (bus.PSR_C),
    .NEXT_ADDR (next_addr)
  );

`ifdef CS_TIMEOUT_EN
  logic bus_err_q, bus_err_d;
`else
  // Timeout configuration only matters when the timeout logic is built.
  logic unused_timeout_cfg;
  assign unused_timeout_cfg = ^{TRAP_ADDR, TIMEOUT_CYCLES[7:0]};
`endif

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    cs_d    = cs_q;
`ifdef CS_TIMEOUT_EN
    bus_err_d = 1'b0;
`endif
    case (state_q)
      ST_RUN: begin
        if (bus.MEM_REQ && !bus.ACK) begin
          state_d = ST_WAIT;
          cnt_d   = 8'd1;
        end else begin
          cs_d = next_addr;
        end
      end
      ST_WAIT: begin
        if (bus.ACK) begin
          cs_d    = next_addr;
          state_d = ST_RUN;
          cnt_d   = 8'd0;
        end
`ifdef CS_TIMEOUT_EN
        else if (cnt_q == 8'(TIMEOUT_CYCLES)) begin
          cs_d      = TRAP_ADDR;
          bus_err_d = 1'b1;
          state_d   = ST_RUN;
          cnt_d     = 8'd0;
        end
`endif
        else if (cnt_q != 8'hFF) begin
          cnt_d = cnt_q + 8'd1;
        end
      end
      default: state_d = ST_RUN;
    endcase
  end

  always_ff @(posedge CLK) begin
    if (!RESET) begin
      state_q <= ST_RUN;
      cnt_q   <= 8'd0;
      cs_q    <= '0;
`ifdef CS_TIMEOUT_EN
      bus_err_q <= 1'b0;
`endif
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      cs_q    <= cs_d;
`ifdef CS_TIMEOUT_EN
      bus_err_q <= bus_err_d;
`endif
    end
  end

  assign bus.CS_OUT = cs_q;
  assign bus.STALL  = (state_q == ST_WAIT);
`ifdef CS_TIMEOUT_EN
  assign bus.BUS_ERR = bus_err_q;
`else
  assign bus.BUS_ERR = 1'b0;
`endif

endmodule
